// File: rtl/led_display_scan_if.sv
// Bundle of segment-pattern inputs and pin outputs for the display scan driver.
// The master side is the user logic that provides patterns and observes the pins.
// The slave side is the scan driver.
interface led_display_scan_if #(
    parameter int NUM = 4
);
    logic [NUM-1:0][7:0] led_in;
    logic [7:0]          led_display_seg;
    logic [NUM-1:0]      led_display_sel;

    modport master (
        output led_in,
        input  led_display_seg,
        input  led_display_sel
    );

    modport slave (
        input  led_in,
        output led_display_seg,
        output led_display_sel
    );
endinterface

// File: rtl/led_display_scan.sv
// Time-multiplexed scan driver for a NUM-digit, 8-segment display.
// The driver lights one digit at a time. Each digit stays lit for CLK_CYCLE clocks.
// seg and sel are registered together, so a digit and its pattern always change on the same edge.
// The NUM parameter must match the NUM of the connected interface.
module led_display_scan #(
    parameter int   NUM          = 4,
    parameter logic VALID_SIGNAL = 1'b0,
    parameter int   CLK_CYCLE    = 1000
) (
    input  logic              clk,
    input  logic              rstn,
    led_display_scan_if.slave bus
);

    localparam int CNT_W = (CLK_CYCLE > 1) ? $clog2(CLK_CYCLE) : 1;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_CYCLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);

    // The XOR mask is all ones for active-low boards and all zeros for active-high boards.
    // The same mask is also the "everything off" level.
    localparam logic [7:0]     SEG_OFF = {8{~VALID_SIGNAL}};
    localparam logic [NUM-1:0] SEL_OFF = {NUM{~VALID_SIGNAL}};

    logic [CNT_W-1:0] dwell_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic             dwell_done;
    logic [NUM-1:0]   sel_nxt;
    logic [7:0]       seg_nxt;
    logic [NUM-1:0]   sel_q;
    logic [7:0]       seg_q;

    assign dwell_done = (dwell_cnt == CNT_LAST);

    // Dwell counter: counts 0..CLK_CYCLE-1, then wraps.
    // With CLK_CYCLE=1, the counter stays at 0 and every cycle is a wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dwell_cnt <= '0;
        end else if (dwell_done) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

    // Digit index: advances at the end of each dwell period and wraps after the last digit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            digit_idx <= '0;
        end else if (dwell_done) begin
            if (digit_idx == IDX_LAST) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + IDX_W'(1);
            end
        end
    end

    // Decode the index into a one-hot select and pick the live pattern.
    // Both are then mapped to the board's active level.
    always_comb begin
        sel_nxt = '0;
        seg_nxt = '0;
        for (int i = 0; i < NUM; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                sel_nxt[i] = 1'b1;
                seg_nxt    = bus.led_in[i];
            end
        end
        sel_nxt = sel_nxt ^ SEL_OFF;
        seg_nxt = seg_nxt ^ SEG_OFF;
    end

    // Output registers: on reset all outputs are inactive.
    // After reset they follow the decoded digit with one cycle of latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q <= SEL_OFF;
            seg_q <= SEG_OFF;
        end else begin
            sel_q <= sel_nxt;
            seg_q <= seg_nxt;
        end
    end

    assign bus.led_display_sel = sel_q;
    assign bus.led_display_seg = seg_q;

endmodule

// File: tb/tb_led_display_scan.sv
// Bench for led_display_scan. It drives four configurations:
// - a: 4 digits, active-low, 1000-cycle dwell
// - b: 4 digits, active-high, 1-cycle dwell
// - c: 3 digits, active-high, 3-cycle dwell
// - d: 1 digit, active-low, 2-cycle dwell
module tb_led_display_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a;
    logic rstn_b;
    logic rstn_c;

    led_display_scan_if #(.NUM(4)) if_a ();
    led_display_scan_if #(.NUM(4)) if_b ();
    led_display_scan_if #(.NUM(3)) if_c ();
    led_display_scan_if #(.NUM(1)) if_d ();

    led_display_scan #(.NUM(4), .VALID_SIGNAL(1'b0), .CLK_CYCLE(1000)) dut_a (
        .clk(clk), .rstn(rstn_a), .bus(if_a.slave));
    led_display_scan #(.NUM(4), .VALID_SIGNAL(1'b1), .CLK_CYCLE(1)) dut_b (
        .clk(clk), .rstn(rstn_b), .bus(if_b.slave));
    led_display_scan #(.NUM(3), .VALID_SIGNAL(1'b1), .CLK_CYCLE(3)) dut_c (
        .clk(clk), .rstn(rstn_c), .bus(if_c.slave));
    led_display_scan #(.NUM(1), .VALID_SIGNAL(1'b0), .CLK_CYCLE(2)) dut_d (
        .clk(clk), .rstn(rstn_c), .bus(if_d.slave));

    typedef struct {
        logic [3:0][7:0] led_in;
        logic [3:0]      sel;
        logic [7:0]      seg;
    } vec_t;

    vec_t vecs [9];

    int n_cmp = 0;
    int n_bad = 0;
    int t_a   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference rule: after the t-th edge since release, digit ((t-1)/cc) mod num is shown.
    function automatic int digit_of(input int t, input int cc, input int num);
        return ((t - 1) / cc) % num;
    endfunction

    // Runs DUT a for a number of cycles and checks every cycle against the rule.
    task automatic run_a(input int cycles);
        logic [3:0][7:0] pat;
        logic [3:0]      es;
        logic [7:0]      eg;
        int              d;
        for (int k = 0; k < cycles; k++) begin
            pat = if_a.led_in;
            @(negedge clk);
            t_a++;
            d  = digit_of(t_a, 1000, 4);
            es = ~(4'b0001 << d);
            eg = ~pat[d];
            chk("a_sel", 32'(if_a.led_display_sel), 32'(es));
            chk("a_seg", 32'(if_a.led_display_seg), 32'(eg));
        end
    endtask

    initial begin
        logic [2:0][7:0] pc;
        logic [7:0]      pd;
        logic [2:0]      esc;
        logic [7:0]      egc;
        logic            esd;
        logic [7:0]      egd;
        logic            run;
        int              t_c;
        int              dc;

        vecs[0] = '{led_in: {8'h00, 8'h55, 8'hAA, 8'hFF}, sel: 4'b0001, seg: 8'hFF};
        vecs[1] = '{led_in: {8'h00, 8'h55, 8'hAA, 8'hFF}, sel: 4'b0010, seg: 8'hAA};
        vecs[2] = '{led_in: {8'h00, 8'h55, 8'hAA, 8'hFF}, sel: 4'b0100, seg: 8'h55};
        vecs[3] = '{led_in: {8'h00, 8'h55, 8'hAA, 8'hFF}, sel: 4'b1000, seg: 8'h00};
        vecs[4] = '{led_in: {8'h00, 8'h55, 8'hAA, 8'hFF}, sel: 4'b0001, seg: 8'hFF};
        vecs[5] = '{led_in: {8'h12, 8'h34, 8'h56, 8'h78}, sel: 4'b0010, seg: 8'h56};
        vecs[6] = '{led_in: {8'h12, 8'h34, 8'h56, 8'h78}, sel: 4'b0100, seg: 8'h34};
        vecs[7] = '{led_in: {8'h12, 8'h34, 8'h56, 8'h78}, sel: 4'b1000, seg: 8'h12};
        vecs[8] = '{led_in: {8'h00, 8'h00, 8'h00, 8'h81}, sel: 4'b0001, seg: 8'h81};

        rstn_a = 1'b0;
        rstn_b = 1'b0;
        rstn_c = 1'b0;
        if_a.led_in = {8'h00, 8'h55, 8'hAA, 8'hFF};
        if_b.led_in = {8'h00, 8'h55, 8'hAA, 8'hFF};
        if_c.led_in = '0;
        if_d.led_in = '0;
        repeat (3) @(negedge clk);

        // Reset state of every configuration
        chk("rst_a_sel", 32'(if_a.led_display_sel), 32'h0000000F);
        chk("rst_a_seg", 32'(if_a.led_display_seg), 32'h000000FF);
        chk("rst_b_sel", 32'(if_b.led_display_sel), 32'h00000000);
        chk("rst_b_seg", 32'(if_b.led_display_seg), 32'h00000000);
        chk("rst_c_sel", 32'(if_c.led_display_sel), 32'h00000000);
        chk("rst_d_sel", 32'(if_d.led_display_sel), 32'h00000001);
        chk("rst_d_seg", 32'(if_d.led_display_seg), 32'h000000FF);

        // Two full frames, then halfway into digit 0 of the third frame
        rstn_a = 1'b1;
        t_a    = 0;
        run_a(8500);

        // The pattern is sampled live: a change mid-dwell shows on the next cycle
        if_a.led_in[0] = 8'h3C;
        run_a(1);
        chk("a_live_seg", 32'(if_a.led_display_seg), 32'h000000C3);
        chk("a_live_sel", 32'(if_a.led_display_sel), 32'h0000000E);

        // Move into digit 2, then assert reset between clock edges
        run_a(1999);
        chk("a_mid2_sel", 32'(if_a.led_display_sel), 32'h0000000B);
        rstn_a = 1'b0;
        #1;
        chk("a_async_sel", 32'(if_a.led_display_sel), 32'h0000000F);
        chk("a_async_seg", 32'(if_a.led_display_seg), 32'h000000FF);
        @(negedge clk);
        chk("a_hold_sel", 32'(if_a.led_display_sel), 32'h0000000F);
        rstn_a = 1'b1;
        t_a    = 0;
        run_a(1);
        chk("a_restart_sel", 32'(if_a.led_display_sel), 32'h0000000E);
        run_a(1000);
        chk("a_restart_d1", 32'(if_a.led_display_sel), 32'h0000000D);

        // Active-high outputs with a single-cycle dwell, from the vector table
        rstn_b = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if_b.led_in = vecs[i].led_in;
            @(negedge clk);
            chk($sformatf("b_vec%0d_sel", i), 32'(if_b.led_display_sel), 32'(vecs[i].sel));
            chk($sformatf("b_vec%0d_seg", i), 32'(if_b.led_display_seg), 32'(vecs[i].seg));
        end

        // Randomized patterns with occasional reset pulses (configurations c and d)
        t_c = 0;
        pc  = 24'($urandom);
        pd  = 8'($urandom);
        if_c.led_in = pc;
        if_d.led_in = pd;
        rstn_c = 1'b1;
        for (int k = 0; k < 600; k++) begin
            run = rstn_c;
            @(negedge clk);
            if (run) begin
                t_c++;
                dc  = digit_of(t_c, 3, 3);
                esc = 3'b001 << dc;
                egc = pc[dc];
                esd = 1'b0;
                egd = ~pd;
            end else begin
                t_c = 0;
                esc = 3'b000;
                egc = 8'h00;
                esd = 1'b1;
                egd = 8'hFF;
            end
            chk("c_sel", 32'(if_c.led_display_sel), 32'(esc));
            chk("c_seg", 32'(if_c.led_display_seg), 32'(egc));
            chk("d_sel", 32'(if_d.led_display_sel), 32'(esd));
            chk("d_seg", 32'(if_d.led_display_seg), 32'(egd));
            pc = 24'($urandom);
            pd = 8'($urandom);
            if_c.led_in = pc;
            if_d.led_in = pd;
            rstn_c = ($urandom_range(0, 39) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
